data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Byte-addressed data memory for the RV32IC CPU. It serves load/store instructions from the MEM stage.
- Supports byte, halfword and word accesses, little-endian.
- Writes are synchronous. Reads are combinational.
- Storage is cleared by an asynchronous active-low reset.

Parameters:
- ADDR_W, 6, byte-address width; depth = 2**ADDR_W bytes (64 by default).
- DATA_W, 32, data path width; fixed at 32, a parameter for documentation only.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  asynchronous, active-low reset; clears the entire array.
- MemRead  input  1  read enable; when 1, data_out carries the addressed data.
- MemWrite  input  1  write enable; when 1, the store is committed at the rising clk edge.
- mode  input  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- addr  input  ADDR_W  byte address of the lowest byte of the access.
- data_in  input  32  store data; the low byte/half/word is used according to mode.
- data_out  output  32  load data.

Behaviour:
- Storage: array of 2**ADDR_W 8-bit bytes. Little-endian: the byte at addr is bits [7:0], addr+1 is [15:8], and so on.
- Reset:
  - While rst=0, all bytes are 0 immediately, independent of clk.
  - Writes are blocked while rst=0.
  - data_out follows the rules below, so a read during reset returns 0.
- Write, committed on the rising clk edge when rst=1 and MemWrite=1:
  - mode 00: mem[addr] <= data_in[7:0].
  - mode 01: mem[addr] <= data_in[7:0]; mem[addr+1] <= data_in[15:8].
  - mode 10 or 11: 4 bytes, mem[addr..addr+3] <= data_in[7:0] .. data_in[31:24].
- Read is combinational, with zero cycles of latency:
  - If MemRead=0: data_out = 32'h0.
  - mode 00: {24'h0, mem[addr]}.
  - mode 01: {16'h0, mem[addr+1], mem[addr]}.
  - mode 10/11: {mem[addr+3], mem[addr+2], mem[addr+1], mem[addr]}.
- Alignment is not enforced. Byte addresses addr+k are computed modulo 2**ADDR_W, so accesses wrap around (e.g. a word at addr 62 uses bytes 62, 63, 0, 1).
- Simultaneous MemRead and MemWrite to the same location:
  - data_out shows the old contents until the clock edge and the new contents after it.
  - There is no write-first bypass.
- Reset asserted in the same cycle as a write: reset wins and the write is lost.
- No error outputs; out-of-range addresses are impossible by construction.

Optional Feature:
- Macro MEM_SIGNEXT_EN.
- When defined, reads in modes 00 and 01 are sign-extended (bit 7 or bit 15 replicated into the upper bits), matching LB/LH.
- When undefined, byte/half reads are zero-extended as above, and the CPU performs any extension itself.
- Word reads and all writes are identical in both builds.

Decomposition:
- Shared package mem_pkg holds:
  - localparams MODE_BYTE=2'b00, MODE_HALF=2'b01, MODE_WORD=2'b10;
  - the typedef mem_mode_t (2-bit);
  - the constant DATA_W=32.
- The CPU decoder uses the same constants.
- One natural sub-module, mem_read_format: a purely combinational block taking the four raw bytes, mode and MemRead, and producing data_out (masking plus optional sign extension).
- The byte array and write logic stay in data_memory.

Test Plan:
1. Reset: hold rst=0 for 20 ns, then read word at addr 0 with MemRead=1 -> data_out=32'h0; check several addresses.
2. Word write/read: rst=1, mode=10, addr=0, data_in=15, MemWrite=1 for one edge, then MemRead=1 -> 32'h0000000F.
3. Sizes and endianness:
   - Write word 32'hA1B2C3D4 at addr 8.
   - Byte reads at 8..11 -> 32'hD4, 32'hC3, 32'hB2, 32'hA1.
   - Half reads at 8 and 10 -> 32'hC3D4, 32'hA1B2.
   - MEM_SIGNEXT_EN build: byte read at 8 -> 32'hFFFFFFD4.
4. Partial store:
   - Over the word from step 3, write byte 8'h55 at addr 9 (data_in=32'hFFFFFF55, mode 00).
   - Word read at 8 -> 32'hA1B255D4; upper data_in bits ignored.
5. Wrap-around and gating:
   - Write word 32'h11223344 at addr 62; byte reads at 62, 63, 0, 1 -> 44, 33, 22, 11.
   - MemRead=0 -> data_out=0 regardless of addr.
6. Reset mid-operation:
   - Assert rst=0 between clock edges while MemWrite=1 -> array cleared at once.
   - The next edge with rst still 0 writes nothing.
   - After release, reads return 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and types for the data memory and the CPU decoder.
package mem_pkg;

    localparam int DATA_W = 32;

    typedef logic [1:0] mem_mode_t;

    localparam mem_mode_t MODE_BYTE = 2'b00;
    localparam mem_mode_t MODE_HALF = 2'b01;
    localparam mem_mode_t MODE_WORD = 2'b10;

endpackage : mem_pkg

// File: rtl/mem_read_format.sv
// Load-data formatter: masks the four raw bytes to the access size and gates
// the result with the read enable. Optional macro MEM_SIGNEXT_EN turns byte and
// half reads into sign-extending loads (LB/LH); otherwise they zero-extend.
module mem_read_format
    import mem_pkg::*;
(
    input  logic [7:0]        byte0_i,
    input  logic [7:0]        byte1_i,
    input  logic [7:0]        byte2_i,
    input  logic [7:0]        byte3_i,
    input  mem_mode_t         mode_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] data_o
);

    // Select access width and extension; mode 11 falls through to word.
    always_comb begin
        data_o = '0;
        if (rd_en_i) begin
            case (mode_i)
`ifdef MEM_SIGNEXT_EN
                MODE_BYTE: data_o = {{24{byte0_i[7]}}, byte0_i};
                MODE_HALF: data_o = {{16{byte1_i[7]}}, byte1_i, byte0_i};
`else
                MODE_BYTE: data_o = {24'h0, byte0_i};
                MODE_HALF: data_o = {16'h0, byte1_i, byte0_i};
`endif
                default:   data_o = {byte3_i, byte2_i, byte1_i, byte0_i};
            endcase
        end
    end

endmodule : mem_read_format

// File: rtl/data_memory.sv
// Byte-addressed, little-endian data memory for the MEM stage.
// Synchronous writes, combinational reads, whole array cleared by the
// asynchronous active-low reset. Byte addresses wrap modulo the depth, so
// unaligned accesses at the top of the array continue at byte 0.
// Optional macro MEM_SIGNEXT_EN (see mem_read_format) sign-extends byte/half loads.
module data_memory
    import mem_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    mem_mode_t         mode_t;

    assign mode_t = mem_mode_t'(mode);

    // Byte lane addresses; ADDR_W-bit arithmetic gives the wrap for free.
    assign a0 = addr;
    assign a1 = addr + ADDR_W'(1);
    assign a2 = addr + ADDR_W'(2);
    assign a3 = addr + ADDR_W'(3);

    // Next array contents: merge the store bytes selected by the access size.
    always_comb begin
        mem_d = mem_q;
        if (MemWrite) begin
            case (mode_t)
                MODE_BYTE: begin
                    mem_d[a0] = data_in[7:0];
                end
                MODE_HALF: begin
                    mem_d[a0] = data_in[7:0];
                    mem_d[a1] = data_in[15:8];
                end
                default: begin
                    mem_d[a0] = data_in[7:0];
                    mem_d[a1] = data_in[15:8];
                    mem_d[a2] = data_in[23:16];
                    mem_d[a3] = data_in[31:24];
                end
            endcase
        end
    end

    // Byte array; reset clears everything and holds it cleared, so a store
    // coinciding with reset is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    mem_read_format u_read_format (
        .byte0_i (mem_q[a0]),
        .byte1_i (mem_q[a1]),
        .byte2_i (mem_q[a2]),
        .byte3_i (mem_q[a3]),
        .mode_i  (mode_t),
        .rd_en_i (MemRead),
        .data_o  (data_out)
    );

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset clearing, access sizes, endianness,
// partial stores, address wrap, read gating, read/write ordering and reset
// during a store. Expected values are hand-computed.
module tb_data_memory;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  mode;
    logic [5:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    int n_vec = 0;
    int n_err = 0;

    data_memory #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .mode     (mode),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte/half reads with the top data bit set differ between the two builds.
    function automatic logic [31:0] ext8(input logic [7:0] b);
`ifdef MEM_SIGNEXT_EN
        return {{24{b[7]}}, b};
`else
        return {24'h0, b};
`endif
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h);
`ifdef MEM_SIGNEXT_EN
        return {{16{h[15]}}, h};
`else
        return {16'h0, h};
`endif
    endfunction

    task automatic do_write(input logic [5:0] a, input logic [1:0] m, input logic [31:0] d);
        @(negedge clk);
        MemRead  = 1'b0;
        addr     = a;
        mode     = m;
        data_in  = d;
        MemWrite = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [5:0] a, input logic [1:0] m,
                            input logic rd, input logic [31:0] exp);
        @(negedge clk);
        MemWrite = 1'b0;
        addr     = a;
        mode     = m;
        MemRead  = rd;
        #1;
        check(tag, data_out, exp);
    endtask

    initial begin
        rst = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        mode = 2'b10; addr = '0; data_in = '0;
        #20;
        MemRead = 1'b1;
        #1 check("rst_w0", data_out, 32'h0);
        addr = 6'd13; #1 check("rst_w13", data_out, 32'h0);
        addr = 6'd62; #1 check("rst_w62", data_out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        rd_check("post_rst_w32", 6'd32, 2'b10, 1'b1, 32'h0);

        do_write(6'd0, 2'b10, 32'd15);
        rd_check("word_0", 6'd0, 2'b10, 1'b1, 32'h0000000F);

        do_write(6'd8, 2'b10, 32'hA1B2C3D4);
        rd_check("byte_8",  6'd8,  2'b00, 1'b1, ext8(8'hD4));
        rd_check("byte_9",  6'd9,  2'b00, 1'b1, ext8(8'hC3));
        rd_check("byte_10", 6'd10, 2'b00, 1'b1, ext8(8'hB2));
        rd_check("byte_11", 6'd11, 2'b00, 1'b1, ext8(8'hA1));
        rd_check("half_8",  6'd8,  2'b01, 1'b1, ext16(16'hC3D4));
        rd_check("half_10", 6'd10, 2'b01, 1'b1, ext16(16'hA1B2));
        rd_check("half_9",  6'd9,  2'b01, 1'b1, ext16(16'hB2C3));
        rd_check("word_8",  6'd8,  2'b10, 1'b1, 32'hA1B2C3D4);
        rd_check("word11_8", 6'd8, 2'b11, 1'b1, 32'hA1B2C3D4);

        do_write(6'd9, 2'b00, 32'hFFFFFF55);
        rd_check("pstore_w8", 6'd8, 2'b10, 1'b1, 32'hA1B255D4);
        rd_check("pstore_b9", 6'd9, 2'b00, 1'b1, 32'h00000055);

        do_write(6'd20, 2'b01, 32'hFFFFBEEF);
        rd_check("hstore_w20", 6'd20, 2'b10, 1'b1, 32'h0000BEEF);

        do_write(6'd16, 2'b11, 32'h0BADF00D);
        rd_check("m11store_w16", 6'd16, 2'b10, 1'b1, 32'h0BADF00D);

        do_write(6'd62, 2'b10, 32'h11223344);
        rd_check("wrap_b62", 6'd62, 2'b00, 1'b1, 32'h00000044);
        rd_check("wrap_b63", 6'd63, 2'b00, 1'b1, 32'h00000033);
        rd_check("wrap_b0",  6'd0,  2'b00, 1'b1, 32'h00000022);
        rd_check("wrap_b1",  6'd1,  2'b00, 1'b1, 32'h00000011);
        rd_check("wrap_w62", 6'd62, 2'b10, 1'b1, 32'h11223344);
        rd_check("wrap_h63", 6'd63, 2'b01, 1'b1, 32'h00002233);

        rd_check("gate_w8",  6'd8,  2'b10, 1'b0, 32'h0);
        rd_check("gate_w62", 6'd62, 2'b10, 1'b0, 32'h0);
        rd_check("gate_b9",  6'd9,  2'b00, 1'b0, 32'h0);

        // Read and write the same word in one cycle: old data before the edge.
        @(negedge clk);
        addr = 6'd8; mode = 2'b10; data_in = 32'hDEADBEEF;
        MemRead = 1'b1; MemWrite = 1'b1;
        #1 check("rw_before", data_out, 32'hA1B255D4);
        @(posedge clk);
        #1 check("rw_after", data_out, 32'hDEADBEEF);
        MemWrite = 1'b0;

        // Reset between edges while a store is pending.
        @(negedge clk);
        addr = 6'd16; mode = 2'b10; data_in = 32'h12345678;
        MemRead = 1'b1; MemWrite = 1'b1;
        #1 check("pre_rst_w16", data_out, 32'h0BADF00D);
        #1 rst = 1'b0;
        #1 check("rst_clr_w16", data_out, 32'h0);
        @(posedge clk);
        #1 check("rst_blk_w16", data_out, 32'h0);
        @(negedge clk);
        MemWrite = 1'b0;
        rst = 1'b1;
        rd_check("rel_w16", 6'd16, 2'b10, 1'b1, 32'h0);
        rd_check("rel_w8",  6'd8,  2'b10, 1'b1, 32'h0);
        rd_check("rel_w62", 6'd62, 2'b10, 1'b1, 32'h0);
        rd_check("rel_h20", 6'd20, 2'b01, 1'b1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_data_memory
